// File: rtl/arbiter_pkg.sv
// Shared constants, FSM encodings and the round-robin search function for the
// 4-lane drain scheduler.
package arbiter_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ARB   = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  // Searches last+1, last+2, last+3, last (mod 4); the first non-empty lane wins.
  // Returns last when every lane is empty, so callers must qualify with a request.
  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] last,
                                                 input logic [LANES-1:0] empty_vec);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    logic             found;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= LANES; k++) begin
      cand = last + SEL_W'(k);
      if (!found && !empty_vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/rr_grant_4.sv
// Combinational round-robin priority rotator: one-hot grant of the first
// requester after 'last', plus its index.
module rr_grant_4
  import arbiter_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [LANES-1:0] gnt,
  output logic [SEL_W-1:0] gnt_idx
);
  assign gnt_idx = next_lane(last, ~req);
  assign gnt     = (|req) ? (LANES'(1) << gnt_idx) : '0;
endmodule

// File: rtl/arbiter_rr_4x1.sv
// Round-robin scheduler draining four upstream FIFOs into one downstream FIFO,
// honouring downstream almost-full backpressure.
module arbiter_rr_4x1
  import arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 12
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic                 fifo_empty2,
  input  logic                 fifo_empty3,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic [DATA_SIZE-1:0] data_in1,
  input  logic [DATA_SIZE-1:0] data_in2,
  input  logic [DATA_SIZE-1:0] data_in3,
  input  logic                 almost_full,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 pop2,
  output logic                 pop3,
  output logic                 push,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [SEL_W-1:0]     sel,
  output logic [1:0]           state
);
  // Handshake: pop_i is a one-cycle read strobe issued only when lane i is
  // non-empty in that same cycle; the FIFO presents the word the next cycle,
  // when push is high and data_out carries it. almost_full suppresses new pops
  // in the cycle it is seen; an already issued pop still pushes one cycle later.

  state_t           state_q, state_d;
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] sel_q;
  logic             push_q;
  logic [LANES-1:0] req;
  logic [LANES-1:0] gnt;
  logic [LANES-1:0] pop_vec;
  logic [SEL_W-1:0] gnt_idx;
  logic             any_req;
  logic             grant_en;

  assign req      = ~{fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};
  assign any_req  = |req;
  assign grant_en = (state_q == ST_ARB) && !almost_full && any_req;

  rr_grant_4 u_grant (
    .req     (req),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign pop_vec = grant_en ? gnt : '0;
  assign {pop3, pop2, pop1, pop0} = pop_vec;

  // IDLE and ARB leave on the same conditions; only ARB issues grants.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE, ST_ARB: begin
        if (almost_full)  state_d = ST_STALL;
        else if (any_req) state_d = ST_ARB;
        else              state_d = ST_IDLE;
      end
      ST_STALL: begin
        if (!almost_full) state_d = any_req ? ST_ARB : ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      last_q  <= 2'd3;
      sel_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= grant_en;
      if (grant_en) begin
        last_q <= gnt_idx;
        sel_q  <= gnt_idx;
      end
    end
  end

  // Mux on the registered select so synchronous-read FIFO data lines up.
  always_comb begin
    data_out = '0;
    if (push_q) begin
      case (sel_q)
        2'd0:    data_out = data_in0;
        2'd1:    data_out = data_in1;
        2'd2:    data_out = data_in2;
        default: data_out = data_in3;
      endcase
    end
  end

  assign push  = push_q;
  assign sel   = sel_q;
  assign state = state_q;
endmodule

// File: tb/tb_arbiter_rr_4x1.sv
// Directed bench for arbiter_rr_4x1 with a synchronous-read FIFO model per lane.
module tb_arbiter_rr_4x1;
  logic        clk = 1'b0;
  logic        reset_L;
  logic        almost_full;
  logic        fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3;
  logic [11:0] rd_data [4];
  logic        pop0, pop1, pop2, pop3, push;
  logic [11:0] data_out;
  logic [1:0]  sel, state;
  logic [3:0]  pop_v;

  logic [11:0] mem [4][16];
  logic [3:0]  head [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0]  tail [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arbiter_rr_4x1 #(.DATA_SIZE(12)) dut (
    .clk(clk), .reset_L(reset_L),
    .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1),
    .fifo_empty2(fifo_empty2), .fifo_empty3(fifo_empty3),
    .data_in0(rd_data[0]), .data_in1(rd_data[1]),
    .data_in2(rd_data[2]), .data_in3(rd_data[3]),
    .almost_full(almost_full),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .push(push), .data_out(data_out), .sel(sel), .state(state)
  );

  assign pop_v = {pop3, pop2, pop1, pop0};
  assign fifo_empty0 = (head[0] == tail[0]);
  assign fifo_empty1 = (head[1] == tail[1]);
  assign fifo_empty2 = (head[2] == tail[2]);
  assign fifo_empty3 = (head[3] == tail[3]);

  // Upstream FIFOs: word appears on rd_data the cycle after its pop.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_v[i]) begin
        rd_data[i] <= mem[i][head[i]];
        head[i]    <= head[i] + 4'd1;
      end
    end
  end

  task automatic load(input int lane, input logic [11:0] word);
    mem[lane][tail[lane]] = word;
    tail[lane] = tail[lane] + 4'd1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    almost_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total += 5;
    if (state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", state); bad++; end
    if (pop_v !== 4'b0) begin $display("FAIL reset_pop got=%b exp=0000", pop_v); bad++; end
    if (push !== 1'b0) begin $display("FAIL reset_push got=%b exp=0", push); bad++; end
    if (data_out !== 12'h0) begin $display("FAIL reset_data got=%h exp=000", data_out); bad++; end
    if (sel !== 2'd0) begin $display("FAIL reset_sel got=%0d exp=0", sel); bad++; end
    @(negedge clk);
    reset_L = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      total += 3;
      if (state !== 2'd1) begin $display("FAIL idle_state c=%0d got=%0d exp=1", c, state); bad++; end
      if (pop_v !== 4'b0) begin $display("FAIL idle_pop c=%0d got=%b exp=0000", c, pop_v); bad++; end
      if (push !== 1'b0) begin $display("FAIL idle_push c=%0d got=%b exp=0", c, push); bad++; end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ep [6]; logic eu [6]; logic [11:0] ed [6]; logic [1:0] es [6]; logic [1:0] est [6];
    ep  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    eu  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ed  = '{12'h000, 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 12'h000};
    es  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    est = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    @(negedge clk);
    load(0, 12'hAAA); load(1, 12'hBBB); load(2, 12'hCCC); load(3, 12'hDDD);
    #1;
    total++;
    if (pop_v !== 4'b0) begin $display("FAIL rr_idle_pop got=%b exp=0000", pop_v); bad++; end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      total += 5;
      if (pop_v !== ep[c]) begin $display("FAIL rr_pop c=%0d got=%b exp=%b", c, pop_v, ep[c]); bad++; end
      if (push !== eu[c]) begin $display("FAIL rr_push c=%0d got=%b exp=%b", c, push, eu[c]); bad++; end
      if (data_out !== ed[c]) begin $display("FAIL rr_data c=%0d got=%h exp=%h", c, data_out, ed[c]); bad++; end
      if (sel !== es[c]) begin $display("FAIL rr_sel c=%0d got=%0d exp=%0d", c, sel, es[c]); bad++; end
      if (state !== est[c]) begin $display("FAIL rr_state c=%0d got=%0d exp=%0d", c, state, est[c]); bad++; end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ep [5]; logic eu [5]; logic [11:0] ed [5]; logic [1:0] es [5]; logic [1:0] est [5];
    ep  = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    eu  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ed  = '{12'h000, 12'hC01, 12'hC02, 12'hC03, 12'h000};
    es  = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
    est = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    @(negedge clk);
    load(2, 12'hC01); load(2, 12'hC02); load(2, 12'hC03);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total += 5;
      if (pop_v !== ep[c]) begin $display("FAIL b2b_pop c=%0d got=%b exp=%b", c, pop_v, ep[c]); bad++; end
      if (push !== eu[c]) begin $display("FAIL b2b_push c=%0d got=%b exp=%b", c, push, eu[c]); bad++; end
      if (data_out !== ed[c]) begin $display("FAIL b2b_data c=%0d got=%h exp=%h", c, data_out, ed[c]); bad++; end
      if (sel !== es[c]) begin $display("FAIL b2b_sel c=%0d got=%0d exp=%0d", c, sel, es[c]); bad++; end
      if (state !== est[c]) begin $display("FAIL b2b_state c=%0d got=%0d exp=%0d", c, state, est[c]); bad++; end
    end
  endtask

  task automatic test_stall();
    logic [3:0] ep [9]; logic eu [9]; logic [11:0] ed [9]; logic [1:0] es [9]; logic [1:0] est [9]; logic ea [9];
    int guard;
    ea  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ep  = '{4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
    eu  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ed  = '{12'h000, 12'h401, 12'h101, 12'h201, 12'h000, 12'h000, 12'h000, 12'h000, 12'h301};
    es  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    est = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2};
    @(negedge clk);
    for (int l = 0; l < 4; l++)
      for (int k = 1; k <= 3; k++) load(l, 12'(((l + 1) << 8) + k));
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      almost_full = ea[c];
      #1;
      total += 5;
      if (pop_v !== ep[c]) begin $display("FAIL stall_pop c=%0d got=%b exp=%b", c, pop_v, ep[c]); bad++; end
      if (push !== eu[c]) begin $display("FAIL stall_push c=%0d got=%b exp=%b", c, push, eu[c]); bad++; end
      if (data_out !== ed[c]) begin $display("FAIL stall_data c=%0d got=%h exp=%h", c, data_out, ed[c]); bad++; end
      if (sel !== es[c]) begin $display("FAIL stall_sel c=%0d got=%0d exp=%0d", c, sel, es[c]); bad++; end
      if (state !== est[c]) begin $display("FAIL stall_state c=%0d got=%0d exp=%0d", c, state, est[c]); bad++; end
    end
    guard = 0;
    while (!(state == 2'd1 && push == 1'b0) && guard < 60) begin
      @(negedge clk);
      #1;
      guard++;
    end
    total++;
    if (guard >= 60) begin $display("FAIL stall_drain got=state%0d exp=state1 within 60 cycles", state); bad++; end
  endtask

  task automatic test_same_edge();
    logic [3:0] ep [4]; logic eu [4]; logic [11:0] ed [4]; logic [1:0] es [4]; logic [1:0] est [4];
    ep  = '{4'b0001, 4'b1000, 4'b0000, 4'b0000};
    eu  = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed  = '{12'h000, 12'h0A0, 12'h3A0, 12'h000};
    es  = '{2'd0, 2'd0, 2'd3, 2'd3};
    est = '{2'd2, 2'd2, 2'd2, 2'd1};
    @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
    load(0, 12'h0A0); load(3, 12'h3A0);
    #1;
    total += 2;
    if (state !== 2'd1) begin $display("FAIL edge_idle_state got=%0d exp=1", state); bad++; end
    if (pop_v !== 4'b0) begin $display("FAIL edge_idle_pop got=%b exp=0000", pop_v); bad++; end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total += 5;
      if (pop_v !== ep[c]) begin $display("FAIL edge_pop c=%0d got=%b exp=%b", c, pop_v, ep[c]); bad++; end
      if (push !== eu[c]) begin $display("FAIL edge_push c=%0d got=%b exp=%b", c, push, eu[c]); bad++; end
      if (data_out !== ed[c]) begin $display("FAIL edge_data c=%0d got=%h exp=%h", c, data_out, ed[c]); bad++; end
      if (sel !== es[c]) begin $display("FAIL edge_sel c=%0d got=%0d exp=%0d", c, sel, es[c]); bad++; end
      if (state !== est[c]) begin $display("FAIL edge_state c=%0d got=%0d exp=%0d", c, state, est[c]); bad++; end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ep [4]; logic eu [4]; logic [11:0] ed [4]; logic [1:0] es [4]; logic [1:0] est [4];
    @(negedge clk);
    load(0, 12'h011); load(1, 12'h022);
    @(negedge clk);
    #1;
    total += 2;
    if (pop_v !== 4'b0001) begin $display("FAIL mid_pop0 got=%b exp=0001", pop_v); bad++; end
    if (push !== 1'b0) begin $display("FAIL mid_push0 got=%b exp=0", push); bad++; end
    @(negedge clk);
    #1;
    total += 2;
    if (pop_v !== 4'b0010) begin $display("FAIL mid_pop1 got=%b exp=0010", pop_v); bad++; end
    if (data_out !== 12'h011) begin $display("FAIL mid_data1 got=%h exp=011", data_out); bad++; end
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    total += 5;
    if (push !== 1'b0) begin $display("FAIL mid_rst_push got=%b exp=0", push); bad++; end
    if (data_out !== 12'h0) begin $display("FAIL mid_rst_data got=%h exp=000", data_out); bad++; end
    if (pop_v !== 4'b0) begin $display("FAIL mid_rst_pop got=%b exp=0000", pop_v); bad++; end
    if (state !== 2'd0) begin $display("FAIL mid_rst_state got=%0d exp=0", state); bad++; end
    if (sel !== 2'd0) begin $display("FAIL mid_rst_sel got=%0d exp=0", sel); bad++; end
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    total += 2;
    if (push !== 1'b0) begin $display("FAIL mid_hold_push got=%b exp=0", push); bad++; end
    if (state !== 2'd0) begin $display("FAIL mid_hold_state got=%0d exp=0", state); bad++; end
    @(negedge clk);
    load(0, 12'h033); load(2, 12'h044);
    ep  = '{4'b0001, 4'b0100, 4'b0000, 4'b0000};
    eu  = '{1'b0, 1'b1, 1'b1, 1'b0};
    ed  = '{12'h000, 12'h033, 12'h044, 12'h000};
    es  = '{2'd0, 2'd0, 2'd2, 2'd2};
    est = '{2'd2, 2'd2, 2'd2, 2'd1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total += 5;
      if (pop_v !== ep[c]) begin $display("FAIL mid_pop c=%0d got=%b exp=%b", c, pop_v, ep[c]); bad++; end
      if (push !== eu[c]) begin $display("FAIL mid_push c=%0d got=%b exp=%b", c, push, eu[c]); bad++; end
      if (data_out !== ed[c]) begin $display("FAIL mid_data c=%0d got=%h exp=%h", c, data_out, ed[c]); bad++; end
      if (sel !== es[c]) begin $display("FAIL mid_sel c=%0d got=%0d exp=%0d", c, sel, es[c]); bad++; end
      if (state !== est[c]) begin $display("FAIL mid_state c=%0d got=%0d exp=%0d", c, state, est[c]); bad++; end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_same_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/arbiter_rr_4x1.md
Name: arbiter_rr_4x1

Overview:
Round-robin scheduler for the 4-to-1 mux datapath: drains four upstream FIFOs (one per lane) into one downstream FIFO.
- Each cycle it picks at most one non-empty lane, pops it, and steers that lane's read data onto the shared output one cycle later with push asserted.
- Respects downstream almost-full backpressure.
- Sits between the per-lane FIFOs and the merge FIFO, replacing free-running valid strobes.

Parameters:
DATA_SIZE, 12, width of each lane word and of data_out
LANES, 4, number of requesters (fixed at 4; parameter only for package constants)

Ports:
clk  input  1  system clock, all state on rising edge
reset_L  input  1  asynchronous active-low reset
fifo_empty0..fifo_empty3  input  1 each  upstream FIFO i empty flag
data_in0..data_in3  input  DATA_SIZE each  upstream FIFO i read data, valid the cycle after pop_i
almost_full  input  1  downstream FIFO almost-full (threshold leaves ≥2 free entries)
pop0..pop3  output  1 each  read strobe to upstream FIFO i
push  output  1  write strobe to downstream FIFO
data_out  output  DATA_SIZE  word for downstream FIFO, valid when push=1
sel  output  2  lane whose word is on data_out (debug/mux select)
state  output  2  FSM state (debug)

Behaviour:
- Reset (reset_L=0, async): pop0..3=0, push=0, data_out=0, sel=0, state=RESET, rr pointer last=3, so the first grant after reset goes to lane 0.
- FSM states: RESET=0, IDLE=1, ARB=2, STALL=3.
  - RESET -> IDLE on the first clock with reset_L=1. No pops in RESET.
  - IDLE: all empty. -> ARB when any fifo_empty_i=0 and almost_full=0. -> STALL when almost_full=1.
  - ARB: grants every cycle. -> IDLE when all empty. -> STALL when almost_full=1.
  - STALL: no pops. -> ARB when almost_full=0 and any lane non-empty. -> IDLE when almost_full=0 and all empty.
- Grant (combinational in the current cycle, from the registered state/last and the live inputs):
  - Only in ARB, or in the same cycle the next-state logic leaves IDLE/STALL? No: grants occur only while state=ARB and almost_full=0 in that cycle.
  - Search order: last+1, last+2, last+3, last (mod 4). The first lane with fifo_empty_i=0 wins.
  - pop_i=1 for the winner only; at most one pop high per cycle (one-hot or zero).
  - On grant, last <= winner.
- Datapath latency: exactly 1 cycle from pop to push.
  - Registered: push_q <= |pop, sel_q <= winner (sel holds its old value when there is no grant).
  - data_out = push ? data_in[sel] : 0 (combinational mux on the registered sel, for synchronous-read FIFOs).
- Backpressure: almost_full=1 blocks new pops in that same cycle. A pop issued the previous cycle still pushes (in-flight word); the almost-full threshold covers it.
- Fairness: with all four lanes continuously non-empty and no backpressure, the grant order is 0,1,2,3,0,... and each lane gets 1 pop per 4 cycles.
- Empty/pop same edge: empty is sampled combinationally, so a lane that went empty this cycle is never popped.
- Single active lane: that lane is granted every cycle (back-to-back).
- Reset mid-operation:
  - An in-flight word is dropped: push forced 0 immediately.
  - The pointer returns to 3.
  - No pop is asserted while reset_L=0.
- Wrap-around: the pointer is 2 bits; 3+1 wraps to 0.

Decomposition:
- Package arbiter_pkg: state encodings (ST_RESET, ST_IDLE, ST_ARB, ST_STALL), LANES=4, the SEL_W=2 constant, and a next_lane(last, empty_vec) round-robin function.
- One natural sub-module: rr_grant_4 (combinational priority rotator: inputs req[3:0] and last[1:0]; outputs gnt[3:0] and gnt_idx[1:0]). It is reusable by the upcoming per-class scheduler.
- The FSM and datapath registers stay in arbiter_rr_4x1.

Test Plan:
- Reset then all empty for 3 cycles -> state RESET then IDLE; pop0..3=0, push=0, data_out=0.
- Lanes hold 'hAAA, 'hBBB, 'hCCC, 'hDDD (one word each), almost_full=0 -> pops in order 0,1,2,3 on consecutive cycles; push on the next 4 cycles with data_out AAA, BBB, CCC, DDD; sel=0,1,2,3; then IDLE.
- Only lane 2 non-empty with 3 words (C01, C02, C03) -> pop2 high 3 cycles back-to-back; data_out C01, C02, C03 one cycle later; pointer=2.
- All lanes full; almost_full raised the cycle after the pop of lane 1 -> no pop that cycle; lane 1's word still pushed; STALL held; after almost_full drops, the next grant is lane 2.
- Lane 0 empty goes 0 in the same cycle as lane 3 with pointer=3 -> lane 0 granted first (rotation start), then lane 3.
- reset_L pulsed low mid-stream after a pop of lane 1 -> push=0 immediately, no push of lane 1's word; after release, first grant is lane 0.
